// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the sync_fifo family.
package sync_fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy needs one bit more than the pointers to represent "full".
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
  parameter int DEPTH    = 8,
  parameter int DATA_WID = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AW-1:0]       i_waddr,
  input  logic [DATA_WID-1:0] i_wdata,
  input  logic [AW-1:0]       i_raddr,
  output logic [DATA_WID-1:0] o_rdata
);

  logic [DATA_WID-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// flags, synchronous flush and overflow/underflow pulses.
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DATA_WID  = 8,
  parameter int MODE      = FIFO_MODE_REG,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       wr_en,
  input  logic [DATA_WID-1:0]        data_in,
  input  logic                       rd_en,
  input  logic                       flush,
  output logic [DATA_WID-1:0]        data_out,
  output logic                       data_vld,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [lvl_w(DEPTH)-1:0]    level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if (MODE != FIFO_MODE_REG && MODE != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_ext: MODE must be 0 or 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_ext: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_ext: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_ovf;
  logic                r_udf;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [DATA_WID-1:0] w_rdata;

  assign full         = (r_level == LVL_W'(DEPTH));
  assign empty        = (r_level == '0);
  assign almost_full  = (r_level >= LVL_W'(AF_THRESH));
  assign almost_empty = (r_level <= LVL_W'(AE_THRESH));
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  // Flush overrides both requests, so storage must not be written on that edge.
  sync_fifo_mem #(
    .DEPTH    (DEPTH),
    .DATA_WID (DATA_WID)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_acc && !flush),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      r_ovf <= wr_en && full;
      r_udf <= rd_en && empty;
    end
  end

  if (MODE == FIFO_MODE_FWFT) begin : g_fwft
    // Head is shown only while it holds a real entry, so reset reads as zero.
    assign data_out = empty ? '0 : w_rdata;
    assign data_vld = !empty;
  end else begin : g_reg
    logic [DATA_WID-1:0] r_dout;
    logic                r_dvld;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_dout <= '0;
        r_dvld <= 1'b0;
      end else if (flush) begin
        r_dvld <= 1'b0;
      end else begin
        r_dvld <= w_rd_acc;
        if (w_rd_acc) r_dout <= w_rdata;
      end
    end

    assign data_out = r_dout;
    assign data_vld = r_dvld;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: one registered-read and one FWFT instance.
module tb_sync_fifo_ext;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       wr0 = 0, rd0 = 0, fl0 = 0;
  logic [7:0] din0 = '0;
  logic [7:0] do0;
  logic       dv0, full0, empty0, af0, ae0, ov0, un0;
  logic [3:0] lvl0;

  logic       wr1 = 0, rd1 = 0, fl1 = 0;
  logic [7:0] din1 = '0;
  logic [7:0] do1;
  logic       dv1, full1, empty1, af1, ae1, ov1, un1;
  logic [3:0] lvl1;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  sync_fifo_ext #(.DEPTH(8), .DATA_WID(8), .MODE(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .wr_en(wr0), .data_in(din0), .rd_en(rd0), .flush(fl0),
    .data_out(do0), .data_vld(dv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(lvl0),
    .overflow(ov0), .underflow(un0)
  );

  sync_fifo_ext #(.DEPTH(8), .DATA_WID(8), .MODE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .wr_en(wr1), .data_in(din1), .rd_en(rd1), .flush(fl1),
    .data_out(do1), .data_vld(dv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(lvl1),
    .overflow(ov1), .underflow(un1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Registered-read monitor: every data_vld cycle must match the next expected word.
  always @(negedge clk) begin
    if (rstn && dv0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL m0_unexpected actual=%0h required=none", do0);
      end else begin
        logic [7:0] e;
        e = q0.pop_front();
        if (do0 !== e) begin
          errors++;
          $display("FAIL m0_data actual=%0h required=%0h", do0, e);
        end
      end
    end
  end

  // FWFT monitor: the head presented while popping must match the next expected word.
  always @(negedge clk) begin
    if (rstn && dv1 && rd1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL m1_unexpected actual=%0h required=none", do1);
      end else begin
        logic [7:0] e;
        e = q1.pop_front();
        if (do1 !== e) begin
          errors++;
          $display("FAIL m1_data actual=%0h required=%0h", do1, e);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lvl0"},  lvl0,   0);
    chk({tag, "_emp0"},  empty0, 1);
    chk({tag, "_full0"}, full0,  0);
    chk({tag, "_ae0"},   ae0,    1);
    chk({tag, "_af0"},   af0,    0);
    chk({tag, "_dv0"},   dv0,    0);
    chk({tag, "_do0"},   do0,    0);
    chk({tag, "_ov0"},   ov0,    0);
    chk({tag, "_un0"},   un0,    0);
    chk({tag, "_lvl1"},  lvl1,   0);
    chk({tag, "_emp1"},  empty1, 1);
    chk({tag, "_dv1"},   dv1,    0);
    chk({tag, "_do1"},   do1,    0);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_vals("rst");
    rstn = 1'b1;
    tick();

    // Registered read of three words
    wr0 = 1;
    din0 = 8'hA1; tick();
    din0 = 8'hB2; tick();
    din0 = 8'hC3; tick();
    wr0 = 0;
    chk("t1_lvl3", lvl0, 3);
    chk("t1_ae_at3", ae0, 0);
    rd0 = 1;
    q0.push_back(8'hA1); tick();
    q0.push_back(8'hB2); tick();
    q0.push_back(8'hC3); tick();
    rd0 = 0;
    tick();
    chk("t1_lvl0", lvl0, 0);
    chk("t1_empty", empty0, 1);
    chk("t1_dv_off", dv0, 0);

    // Fill with flag tracking, then overflow
    wr0 = 1;
    for (int i = 1; i <= 8; i++) begin
      din0 = 8'h10 + 8'(i - 1);
      tick();
      chk($sformatf("fill_lvl%0d", i), lvl0, i);
      chk($sformatf("fill_af%0d", i), af0, (i >= 7) ? 1 : 0);
      chk($sformatf("fill_ae%0d", i), ae0, (i <= 1) ? 1 : 0);
    end
    chk("fill_full", full0, 1);
    din0 = 8'hFF;
    tick();
    wr0 = 0;
    chk("ovf_pulse", ov0, 1);
    chk("ovf_lvl", lvl0, 8);
    chk("ovf_full", full0, 1);
    tick();
    chk("ovf_clear", ov0, 0);
    rd0 = 1;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(8'h10 + 8'(i));
      tick();
      chk($sformatf("drain_lvl%0d", i), lvl0, 7 - i);
      chk($sformatf("drain_af%0d", i), af0, ((7 - i) >= 7) ? 1 : 0);
    end
    rd0 = 0;
    tick();
    chk("drain_empty", empty0, 1);
    chk("drain_ae", ae0, 1);

    // Underflow with simultaneous write into empty FIFO
    rd0 = 1; wr0 = 1; din0 = 8'h5A;
    tick();
    rd0 = 0; wr0 = 0;
    chk("udf_pulse", un0, 1);
    chk("udf_lvl", lvl0, 1);
    chk("udf_no_ovf", ov0, 0);
    tick();
    chk("udf_clear", un0, 0);
    rd0 = 1;
    q0.push_back(8'h5A);
    tick();
    rd0 = 0;
    tick();

    // Flush beats a concurrent write
    wr0 = 1;
    for (int i = 0; i < 5; i++) begin
      din0 = 8'h20 + 8'(i);
      tick();
    end
    chk("pre_flush_lvl", lvl0, 5);
    fl0 = 1; din0 = 8'h77;
    tick();
    fl0 = 0; wr0 = 0;
    chk("flush_lvl", lvl0, 0);
    chk("flush_empty", empty0, 1);
    chk("flush_ov", ov0, 0);
    wr0 = 1; din0 = 8'h33;
    tick();
    wr0 = 0;
    chk("post_flush_lvl", lvl0, 1);
    rd0 = 1;
    q0.push_back(8'h33);
    tick();
    rd0 = 0;
    tick();

    // FWFT: head visible before any read
    wr1 = 1; din1 = 8'hD4;
    tick();
    wr1 = 0;
    chk("fwft_head_d4", do1, 8'hD4);
    chk("fwft_vld", dv1, 1);
    wr1 = 1; din1 = 8'hE5;
    tick();
    wr1 = 0;
    q1.push_back(8'hD4);
    rd1 = 1;
    tick();
    rd1 = 0;
    chk("fwft_head_e5", do1, 8'hE5);
    chk("fwft_vld_e5", dv1, 1);
    q1.push_back(8'hE5);
    rd1 = 1;
    tick();
    rd1 = 0;
    chk("fwft_empty", empty1, 1);
    chk("fwft_vld_off", dv1, 0);

    // FWFT streaming with concurrent write and pop
    wr1 = 1;
    din1 = 8'h01; tick();
    din1 = 8'h02; tick();
    q1.push_back(8'h01); q1.push_back(8'h02);
    q1.push_back(8'h03); q1.push_back(8'h04);
    rd1 = 1;
    din1 = 8'h03; tick();
    din1 = 8'h04; tick();
    wr1 = 0;
    tick();
    tick();
    rd1 = 0;
    chk("stream_empty", empty1, 1);
    chk("stream_udf", un1, 0);

    // Asynchronous reset in the middle of a write burst
    wr0 = 1; wr1 = 1;
    for (int i = 0; i < 3; i++) begin
      din0 = 8'h40 + 8'(i);
      din1 = 8'h50 + 8'(i);
      tick();
    end
    chk("burst_lvl0", lvl0, 3);
    chk("burst_lvl1", lvl1, 3);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("arst");
    wr0 = 0; wr1 = 0;
    tick();
    rstn = 1'b1;
    tick();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO, successor to the basic `sync_fifo`, for buffering between producer and consumer datapaths in one clock domain. It adds:
- a selectable read mode: registered output, or first-word-fall-through (FWFT);
- an occupancy count with programmable almost-full and almost-empty flags;
- a synchronous flush;
- one-cycle overflow and underflow error pulses.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of two, ≥ 2.
- `DATA_WID`, 8: data width in bits.
- `MODE`, 0: 0 = registered read, 1 = FWFT.
- `AF_THRESH`, DEPTH-1: `almost_full` asserts when level ≥ AF_THRESH. Legal range 1..DEPTH.
- `AE_THRESH`, 1: `almost_empty` asserts when level ≤ AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset: one clock; asynchronous, active-low.
- `wr_en`  in  1  write request.
- `data_in`  in  DATA_WID  write data.
- `rd_en`  in  1  read (pop) request.
- `flush`  in  1  synchronous clear.
- `data_out`  out  DATA_WID  read data.
- `data_vld`  out  1  `data_out` is valid.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `almost_full`  out  1  level ≥ AF_THRESH.
- `almost_empty`  out  1  level ≤ AE_THRESH.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  one-cycle pulse: write rejected.
- `underflow`  out  1  one-cycle pulse: read rejected.

## Operation
- Pointers `wr_ptr`/`rd_ptr` are $clog2(DEPTH) bits and wrap naturally at DEPTH. `level` is a separate counter.
- Write accepted iff `wr_en && !full`. Read accepted iff `rd_en && !empty`. `full`/`empty` are the values before the edge.
- Accepted write and accepted read in the same cycle: level unchanged, both pointers advance.
- Write while full: no state change; `overflow`=1 next cycle.
- Read while empty: `underflow`=1 next cycle. This includes a simultaneous write to an empty FIFO: the write is accepted, the read is rejected.
- `flush` has priority over `wr_en`/`rd_en` on the same edge:
  - pointers and level go to 0; `data_vld` goes to 0;
  - `overflow`/`underflow` are not raised;
  - storage contents are not cleared.
- `full`, `empty`, `almost_full` and `almost_empty` are decoded from the `level` register, so they change on the same edge as `level`.
- MODE 0: on an accepted read, `data_out` is registered with the head entry and `data_vld`=1 for exactly that next cycle. `data_out` holds its last value otherwise.
- MODE 1: `data_out` = head entry combinationally and `data_vld` = `!empty`. `rd_en` pops the entry.
- Reset values: `level` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` 0, `data_vld` 0, `data_out` 0, `overflow` 0, `underflow` 0.
- Reset mid-operation discards all entries immediately (asynchronous).

## Timing
- Write at edge N: `level`/`empty` update at N. Entry readable by a read request in cycle N+1.
- MODE 0 read latency: `rd_en` sampled at edge N; `data_out`/`data_vld` valid in cycle N to N+1.
- MODE 1: head entry visible in the cycle after the write edge. After a pop, the next entry is visible in the cycle after the pop edge.
- Back-to-back reads and writes sustain 1 word/cycle.
- Error pulses are registered: they appear one cycle after the offending request.

## Structure
- Package `sync_fifo_pkg`: mode constants `FIFO_MODE_REG`=0 and `FIFO_MODE_FWFT`=1, plus the level-width function.
- Sub-module `sync_fifo_mem`: DEPTH×DATA_WID array with one synchronous write port and one asynchronous read port.
- Top level holds pointers, level counter, flags, output register and MODE generate branches.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
Use DEPTH=8, DATA_WID=8 unless stated.
- MODE 0: write A1,B2,C3, then read ×3 → `data_out` A1,B2,C3, each with a 1-cycle `data_vld` one cycle after `rd_en`; `level` ends at 0 and `empty`=1.
- Fill 8 entries, then 1 extra write of FF → `full`=1, `level`=8, `overflow` pulses once; reading 8 entries returns the original data, FF is never seen.
- Read while empty, with a simultaneous write of 5A → `underflow` pulses, `level`=1; the next read returns 5A.
- Defaults AF_THRESH=7, AE_THRESH=1: `almost_full` asserts at the 7th write and deasserts when level drops to 6. `almost_empty`=1 at level ≤ 1 and 0 at level 2.
- MODE 1: write D4 → next cycle `data_out`=D4 with `data_vld`=1 before any `rd_en`. Write E5, then pop → `data_out`=E5 the following cycle.
- With 5 entries, assert `flush` together with `wr_en` → `level`=0, `empty`=1, no write taken. Separately, `rstn` low mid-burst → all outputs return to reset values asynchronously.
